// File: rtl/prv32_pkg.sv
// prv32 shared definitions: ALU codes, register index
// width, forward selects and the ID/EX bundle.
package prv32_pkg;

   localparam int unsigned REG_AW = 5;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_PASSB = 4'b0011;
   localparam logic [3:0] ALU_OR    = 4'b0100;
   localparam logic [3:0] ALU_AND   = 4'b0101;
   localparam logic [3:0] ALU_XOR   = 4'b0111;
   localparam logic [3:0] ALU_SLL   = 4'b1000;
   localparam logic [3:0] ALU_SRL   = 4'b1001;
   localparam logic [3:0] ALU_SRA   = 4'b1010;
   localparam logic [3:0] ALU_SLT   = 4'b1101;
   localparam logic [3:0] ALU_SLTU  = 4'b1111;

   typedef logic [REG_AW-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      FWD_RF,
      FWD_EXM,
      FWD_WB
   } fwd_sel_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      reg_idx_t    rs1_addr;
      reg_idx_t    rs2_addr;
      reg_idx_t    rd_addr;
      logic [3:0]  alufn;
      logic        asel_pc;
      logic        bsel_imm;
      logic        shamt_imm;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
   } id_ex_t;

endpackage

// File: rtl/prv32_fwd_unit.sv
// Operand bypass select for one source register.
// EX/MEM wins over MEM/WB; x0 is never bypassed.
module prv32_fwd_unit
   import prv32_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic [4:0]  rs_addr_i,
   input  logic [31:0] rs_data_i,
   input  logic        exm_reg_write_i,
   input  logic [4:0]  exm_rd_addr_i,
   input  logic [31:0] exm_result_i,
   input  logic        wb_reg_write_i,
   input  logic [4:0]  wb_rd_addr_i,
   input  logic [31:0] wb_data_i,
   output fwd_sel_e    sel_o,
   output logic [31:0] data_o
);

   logic exm_hit;
   logic wb_hit;

   assign exm_hit = FWD_EN && exm_reg_write_i &&
                    (exm_rd_addr_i != '0) &&
                    (exm_rd_addr_i == rs_addr_i);

   assign wb_hit  = FWD_EN && wb_reg_write_i &&
                    (wb_rd_addr_i != '0) &&
                    (wb_rd_addr_i == rs_addr_i);

   always_comb begin
      sel_o  = FWD_RF;
      data_o = rs_data_i;
      if (exm_hit) begin
         sel_o  = FWD_EXM;
         data_o = exm_result_i;
      end else if (wb_hit) begin
         sel_o  = FWD_WB;
         data_o = wb_data_i;
      end
   end

endmodule

// File: rtl/prv32_id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use bubble insertion, flush and hold.
module prv32_id_ex_stage
   import prv32_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic [4:0]  id_rd_addr,
   input  logic [3:0]  id_alufn,
   input  logic        id_asel_pc,
   input  logic        id_bsel_imm,
   input  logic        id_shamt_imm,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_reg_write,
   input  logic        flush,
   input  logic        ex_hold,
   input  logic        exm_reg_write,
   input  logic [4:0]  exm_rd_addr,
   input  logic [31:0] exm_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd_addr,
   input  logic [31:0] wb_data,
   output logic        stall_id,
   output logic        ex_valid,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [4:0]  ex_shamt,
   output logic [3:0]  ex_alufn,
   output logic [31:0] ex_store_data,
   output logic [31:0] ex_pc,
   output logic [4:0]  ex_rd_addr,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_reg_write
);

   id_ex_t      ex_q;
   id_ex_t      ex_d;
   id_ex_t      id_pkt;
   logic        load_use;
   logic        kill;
   fwd_sel_e    rs1_sel;
   fwd_sel_e    rs2_sel;
   logic [31:0] rs1_fdata;
   logic [31:0] rs2_fdata;
   logic [31:0] fwd_rs1;
   logic [31:0] fwd_rs2;

   assign ex_valid      = ex_q.valid;
   assign ex_pc         = ex_q.pc;
   assign ex_rd_addr    = ex_q.rd_addr;
   assign ex_alufn      = ex_q.alufn;
   assign ex_mem_read   = ex_q.mem_read  & ex_q.valid;
   assign ex_mem_write  = ex_q.mem_write & ex_q.valid;
   assign ex_reg_write  = ex_q.reg_write & ex_q.valid;

   // Checks rs2 even for rs2-less formats; a rare
   // spurious bubble is cheaper than decoding format.
   assign load_use = ex_valid & ex_mem_read & id_valid &
                     (ex_q.rd_addr != '0) &
                     ((ex_q.rd_addr == id_rs1_addr) |
                      (ex_q.rd_addr == id_rs2_addr));

   assign stall_id = rst_n & (load_use | ex_hold) & ~flush;
   assign kill     = flush | (~ex_hold & load_use);

   always_comb begin
      id_pkt           = '0;
      id_pkt.valid     = id_valid;
      id_pkt.pc        = id_pc;
      id_pkt.rs1_data  = id_rs1_data;
      id_pkt.rs2_data  = id_rs2_data;
      id_pkt.imm       = id_imm;
      id_pkt.rs1_addr  = id_rs1_addr;
      id_pkt.rs2_addr  = id_rs2_addr;
      id_pkt.rd_addr   = id_rd_addr;
      id_pkt.alufn     = id_alufn;
      id_pkt.asel_pc   = id_asel_pc;
      id_pkt.bsel_imm  = id_bsel_imm;
      id_pkt.shamt_imm = id_shamt_imm;
      id_pkt.mem_read  = id_mem_read  & id_valid;
      id_pkt.mem_write = id_mem_write & id_valid;
      id_pkt.reg_write = id_reg_write & id_valid;
   end

   always_comb begin
      ex_d = ex_q;
      if (kill) begin
         ex_d.valid     = 1'b0;
         ex_d.mem_read  = 1'b0;
         ex_d.mem_write = 1'b0;
         ex_d.reg_write = 1'b0;
      end else if (!ex_hold) begin
         ex_d = id_pkt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   prv32_fwd_unit #(
      .FWD_EN (FWD_EN)
   ) u_fwd_rs1 (
      .rs_addr_i       (ex_q.rs1_addr),
      .rs_data_i       (ex_q.rs1_data),
      .exm_reg_write_i (exm_reg_write),
      .exm_rd_addr_i   (exm_rd_addr),
      .exm_result_i    (exm_result),
      .wb_reg_write_i  (wb_reg_write),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_data_i       (wb_data),
      .sel_o           (rs1_sel),
      .data_o          (rs1_fdata)
   );

   prv32_fwd_unit #(
      .FWD_EN (FWD_EN)
   ) u_fwd_rs2 (
      .rs_addr_i       (ex_q.rs2_addr),
      .rs_data_i       (ex_q.rs2_data),
      .exm_reg_write_i (exm_reg_write),
      .exm_rd_addr_i   (exm_rd_addr),
      .exm_result_i    (exm_result),
      .wb_reg_write_i  (wb_reg_write),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_data_i       (wb_data),
      .sel_o           (rs2_sel),
      .data_o          (rs2_fdata)
   );

   assign fwd_rs1 = (rs1_sel == FWD_RF) ? ex_q.rs1_data
                                        : rs1_fdata;
   assign fwd_rs2 = (rs2_sel == FWD_RF) ? ex_q.rs2_data
                                        : rs2_fdata;

   assign ex_a          = ex_q.asel_pc  ? ex_q.pc  : fwd_rs1;
   assign ex_b          = ex_q.bsel_imm ? ex_q.imm : fwd_rs2;
   assign ex_shamt      = ex_q.shamt_imm ? ex_q.imm[4:0]
                                         : fwd_rs2[4:0];
   assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_prv32_id_ex_stage.sv
// Scoreboard bench for prv32_id_ex_stage: directed
// cycles push expectations, a negedge monitor checks.
module tb_prv32_id_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic [4:0]  id_rd_addr;
   logic [3:0]  id_alufn;
   logic        id_asel_pc;
   logic        id_bsel_imm;
   logic        id_shamt_imm;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_reg_write;
   logic        flush;
   logic        ex_hold;
   logic        exm_reg_write;
   logic [4:0]  exm_rd_addr;
   logic [31:0] exm_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        stall_id;
   logic        ex_valid;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [4:0]  ex_shamt;
   logic [3:0]  ex_alufn;
   logic [31:0] ex_store_data;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd_addr;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;

   prv32_id_ex_stage #(
      .FWD_EN (1'b1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_pc         (id_pc),
      .id_rs1_data   (id_rs1_data),
      .id_rs2_data   (id_rs2_data),
      .id_imm        (id_imm),
      .id_rs1_addr   (id_rs1_addr),
      .id_rs2_addr   (id_rs2_addr),
      .id_rd_addr    (id_rd_addr),
      .id_alufn      (id_alufn),
      .id_asel_pc    (id_asel_pc),
      .id_bsel_imm   (id_bsel_imm),
      .id_shamt_imm  (id_shamt_imm),
      .id_mem_read   (id_mem_read),
      .id_mem_write  (id_mem_write),
      .id_reg_write  (id_reg_write),
      .flush         (flush),
      .ex_hold       (ex_hold),
      .exm_reg_write (exm_reg_write),
      .exm_rd_addr   (exm_rd_addr),
      .exm_result    (exm_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_data       (wb_data),
      .stall_id      (stall_id),
      .ex_valid      (ex_valid),
      .ex_a          (ex_a),
      .ex_b          (ex_b),
      .ex_shamt      (ex_shamt),
      .ex_alufn      (ex_alufn),
      .ex_store_data (ex_store_data),
      .ex_pc         (ex_pc),
      .ex_rd_addr    (ex_rd_addr),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_reg_write  (ex_reg_write)
   );

   typedef struct {
      string       tag;
      bit          cv;
      logic        valid;
      logic        stall;
      logic        rw;
      logic        mr;
      logic        mw;
      bit          ca;
      logic [31:0] a;
      bit          cb;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [31:0] sd;
      bit          cp;
      logic [31:0] pc;
      logic [3:0]  alufn;
      logic [4:0]  rd;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic cmp(input string n,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t m;
         m = q.pop_front();
         if (m.cv) begin
            cmp({m.tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
            cmp({m.tag, ".stall"}, 32'(stall_id), 32'(m.stall));
            cmp({m.tag, ".rw"}, 32'(ex_reg_write), 32'(m.rw));
            cmp({m.tag, ".mr"}, 32'(ex_mem_read), 32'(m.mr));
            cmp({m.tag, ".mw"}, 32'(ex_mem_write), 32'(m.mw));
         end
         if (m.ca)
            cmp({m.tag, ".a"}, ex_a, m.a);
         if (m.cb) begin
            cmp({m.tag, ".b"}, ex_b, m.b);
            cmp({m.tag, ".shamt"}, 32'(ex_shamt), 32'(m.shamt));
            cmp({m.tag, ".sd"}, ex_store_data, m.sd);
         end
         if (m.cp) begin
            cmp({m.tag, ".pc"}, ex_pc, m.pc);
            cmp({m.tag, ".alufn"}, 32'(ex_alufn), 32'(m.alufn));
            cmp({m.tag, ".rd"}, 32'(ex_rd_addr), 32'(m.rd));
         end
      end
   end

   task automatic id_set(input logic v,
                         input logic [31:0] pc,
                         input logic [4:0] r1a,
                         input logic [31:0] r1d,
                         input logic [4:0] r2a,
                         input logic [31:0] r2d,
                         input logic [31:0] imm,
                         input logic [4:0] rd,
                         input logic [3:0] fn,
                         input logic asel,
                         input logic bsel,
                         input logic shi,
                         input logic mr,
                         input logic mw,
                         input logic rw);
      id_valid     = v;
      id_pc        = pc;
      id_rs1_addr  = r1a;
      id_rs1_data  = r1d;
      id_rs2_addr  = r2a;
      id_rs2_data  = r2d;
      id_imm       = imm;
      id_rd_addr   = rd;
      id_alufn     = fn;
      id_asel_pc   = asel;
      id_bsel_imm  = bsel;
      id_shamt_imm = shi;
      id_mem_read  = mr;
      id_mem_write = mw;
      id_reg_write = rw;
   endtask

   task automatic id_idle();
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic lw_x5(input logic [31:0] pc);
      id_set(1, pc, 2, 32'h1000, 0, 0, 8, 5, 4'b0000,
             0, 1, 0, 1, 0, 1);
   endtask

   task automatic add_x6(input logic [31:0] pc);
      id_set(1, pc, 5, 32'hDEAD, 1, 7, 0, 6, 4'b0000,
             0, 0, 0, 0, 0, 1);
   endtask

   task automatic new_exp(input string tag);
      e     = '{default: '0};
      e.tag = tag;
   endtask

   task automatic x_ctl(input logic v, input logic st,
                        input logic rw, input logic mr,
                        input logic mw);
      e.cv = 1; e.valid = v; e.stall = st;
      e.rw = rw; e.mr = mr; e.mw = mw;
   endtask

   task automatic x_a(input logic [31:0] a);
      e.ca = 1; e.a = a;
   endtask

   task automatic x_b(input logic [31:0] b,
                      input logic [4:0] sh,
                      input logic [31:0] sd);
      e.cb = 1; e.b = b; e.shamt = sh; e.sd = sd;
   endtask

   task automatic x_p(input logic [31:0] pc,
                      input logic [3:0] fn,
                      input logic [4:0] rd);
      e.cp = 1; e.pc = pc; e.alufn = fn; e.rd = rd;
   endtask

   task automatic cyc();
      if (e.cv || e.ca || e.cb || e.cp)
         q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; flush = 0; ex_hold = 0;
      exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
      wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
      id_idle();
      id_valid = 1; id_alufn = 4'b0001; id_reg_write = 1;
      new_exp("r0"); cyc();

      ex_hold = 1;
      new_exp("reset");
      x_ctl(0, 0, 0, 0, 0); x_p(0, 0, 0);
      cyc();

      rst_n = 1; ex_hold = 0;
      id_set(1, 32'h100, 1, 5, 0, 0, 7, 2, 4'b0000,
             0, 1, 0, 0, 0, 1);
      new_exp("adv0"); x_ctl(0, 0, 0, 0, 0); cyc();

      id_set(1, 32'h200, 4, 32'h80, 7, 32'h23,
             32'hFFFF_FFFF, 8, 4'b1000, 1, 0, 0, 0, 1, 0);
      new_exp("adv1"); x_ctl(1, 0, 1, 0, 0);
      x_a(5); x_b(7, 0, 0); x_p(32'h100, 4'b0000, 2);
      cyc();

      id_set(1, 32'h300, 3, 32'hAA, 0, 32'h55, 4, 9,
             4'b0000, 0, 0, 1, 0, 0, 1);
      new_exp("shift"); x_ctl(1, 0, 0, 0, 1);
      x_a(32'h200); x_b(32'h23, 3, 32'h23);
      x_p(32'h200, 4'b1000, 8);
      cyc();

      id_idle(); ex_hold = 1;
      exm_reg_write = 1; exm_rd_addr = 3; exm_result = 32'h11;
      wb_reg_write = 1; wb_rd_addr = 3; wb_data = 32'h22;
      new_exp("fwd_exm"); x_ctl(1, 1, 1, 0, 0);
      x_a(32'h11); x_b(32'h55, 4, 32'h55);
      cyc();

      exm_reg_write = 0;
      new_exp("fwd_wb"); x_ctl(1, 1, 1, 0, 0);
      x_a(32'h22); cyc();

      exm_reg_write = 1; exm_rd_addr = 0;
      wb_rd_addr = 0;
      new_exp("fwd_x0"); x_ctl(1, 1, 1, 0, 0);
      x_a(32'hAA); x_b(32'h55, 4, 32'h55);
      cyc();

      ex_hold = 0; exm_reg_write = 0; wb_reg_write = 0;
      lw_x5(32'h400);
      new_exp("fwd_rf"); x_ctl(1, 0, 1, 0, 0);
      x_a(32'hAA); x_p(32'h300, 4'b0000, 9);
      cyc();

      add_x6(32'h404);
      new_exp("lu_stall"); x_ctl(1, 1, 1, 1, 0);
      x_a(32'h1000); x_b(8, 0, 0);
      x_p(32'h400, 4'b0000, 5);
      cyc();

      new_exp("lu_bubble"); x_ctl(0, 0, 0, 0, 0); cyc();

      id_idle();
      wb_reg_write = 1; wb_rd_addr = 5; wb_data = 32'h1234;
      new_exp("lu_add"); x_ctl(1, 0, 1, 0, 0);
      x_a(32'h1234); x_b(7, 7, 7);
      x_p(32'h404, 4'b0000, 6);
      cyc();

      wb_reg_write = 0;
      lw_x5(32'h500);
      new_exp("fl0"); x_ctl(0, 0, 0, 0, 0); cyc();

      add_x6(32'h504); flush = 1;
      new_exp("fl_lu"); x_ctl(1, 0, 1, 1, 0); cyc();

      flush = 0; id_idle();
      new_exp("fl_kill"); x_ctl(0, 0, 0, 0, 0); cyc();

      id_set(1, 32'h600, 10, 32'h61, 0, 0, 1, 11,
             4'b0000, 0, 1, 0, 0, 0, 1);
      new_exp("h0"); x_ctl(0, 0, 0, 0, 0); cyc();

      ex_hold = 1;
      id_set(1, 32'h700, 12, 32'h71, 0, 0, 1, 13,
             4'b0000, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0)
            id_set(1, 32'h800, 14, 32'h81, 0, 0, 1, 15,
                   4'b0100, 0, 1, 0, 0, 0, 1);
         new_exp($sformatf("hold%0d", i));
         x_ctl(1, 1, 1, 0, 0); x_a(32'h61);
         x_p(32'h600, 4'b0000, 11);
         cyc();
      end

      ex_hold = 0;
      new_exp("h_rel"); x_ctl(1, 0, 1, 0, 0);
      x_a(32'h61); x_p(32'h600, 4'b0000, 11);
      cyc();

      id_idle();
      new_exp("h_load"); x_ctl(1, 0, 1, 0, 0);
      x_a(32'h81); x_p(32'h800, 4'b0100, 15);
      cyc();

      lw_x5(32'h900);
      new_exp("m0"); x_ctl(0, 0, 0, 0, 0); cyc();

      add_x6(32'h904); rst_n = 0;
      new_exp("m_rst"); x_ctl(1, 0, 1, 1, 0); cyc();

      rst_n = 1;
      new_exp("m_clr"); x_ctl(0, 0, 0, 0, 0);
      x_p(0, 0, 0); cyc();

      id_idle();
      new_exp("m_add"); x_ctl(1, 0, 1, 0, 0);
      x_a(32'hDEAD); x_p(32'h904, 4'b0000, 6);
      cyc();

      for (int i = 0; i < 10 && q.size() > 0; i++)
         @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d left expected 0",
                  q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prv32_id_ex_stage.md
Name: prv32_id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage. Sits directly upstream of the EX-stage ALU and produces its a, b, shamt and alufn inputs.
- Latches decoded ID fields each cycle and selects forwarded operands from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, then stalls ID and inserts a bubble.
- Honours branch flush and downstream hold.

Parameters:
- FWD_EN, 1, 1 = forwarding muxes active; 0 = operands taken from the register file only (debug).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active low
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  32  instruction PC
- id_rs1_data, id_rs2_data  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register indices
- id_alufn  in  4  ALU function code
- id_asel_pc  in  1  operand a = PC (AUIPC/JAL)
- id_bsel_imm  in  1  operand b = immediate
- id_shamt_imm  in  1  shamt from imm[4:0], else from forwarded rs2[4:0]
- id_mem_read, id_mem_write, id_reg_write  in  1 each  control bits
- flush  in  1  branch/jump redirect; kill ID->EX transfer
- ex_hold  in  1  downstream busy; freeze EX register
- exm_reg_write  in  1  EX/MEM writes back
- exm_rd_addr  in  5  EX/MEM destination register
- exm_result  in  32  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB writes back
- wb_rd_addr  in  5  MEM/WB destination register
- wb_data  in  32  MEM/WB write data
- stall_id  out  1  ID/IF must hold
- ex_valid  out  1  EX holds a valid instruction
- ex_a, ex_b  out  32 each  ALU operands
- ex_shamt  out  5  shift amount
- ex_alufn  out  4  ALU function code
- ex_store_data  out  32  forwarded rs2 (store data)
- ex_pc  out  32  registered PC
- ex_rd_addr  out  5  registered destination
- ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  qualified control

Behaviour:
- Reset (rst_n=0 at a clk edge): all EX registers cleared. ex_valid=0, all control=0, addresses=0, data=0. stall_id is 0 while in reset.
- Load-use hazard: load_use = ex_valid & ex_mem_read & id_valid & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Flagged even when the instruction does not use rs2; conservative, accepted.
- stall_id = (load_use | ex_hold) & ~flush. Combinational.
- Per-edge register update, priority highest first:
  - 1. !rst_n: clear.
  - 2. flush: ex_valid<=0, controls<=0.
  - 3. ex_hold: all EX registers keep their value.
  - 4. load_use: bubble; ex_valid<=0, controls<=0; data fields don't-care.
  - 5. else: load all id_* fields; ex_valid<=id_valid; controls ANDed with id_valid.
- Output control bits are the registered bits ANDed with ex_valid.
- Forwarding is combinational in EX, per source rsN (registered address and data):
  - If FWD_EN & exm_reg_write & exm_rd_addr!=0 & exm_rd_addr==rsN: use exm_result.
  - Else if FWD_EN & wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==rsN: use wb_data.
  - Else use the registered rsN data.
  - x0 is never forwarded. EX/MEM beats MEM/WB when both match.
- Operand selection:
  - ex_a = asel_pc ? ex_pc : fwd_rs1.
  - ex_b = bsel_imm ? imm : fwd_rs2.
  - ex_shamt = shamt_imm ? imm[4:0] : fwd_rs2[4:0].
  - ex_store_data = fwd_rs2 always.
- A load in EX/MEM is never the forward source for the next instruction; the bubble guarantees a distance of at least 2 (MEM/WB).
- Latency: one cycle from ID to registered EX fields. Forwarded operands are valid in the same cycle as the source stages.
- Simultaneous events:
  - flush with load_use: flush wins, stall_id=0.
  - flush with ex_hold: flush wins.
  - hold with load_use: stall_id=1, EX frozen; the bubble is inserted once the hold clears and the hazard still holds.
- Reset mid-stall: all state cleared; the next cycle's stall_id is re-evaluated from cleared ex_mem_read (=0).

Decomposition:
- Shared package prv32_pkg:
  - ALUFN encodings: ADD 0000, SUB 0001, PASSB 0011, OR 0100, AND 0101, XOR 0111, SLL/SRL/SRA 10xx, SLT 1101, SLTU 1111.
  - Register-index width 5.
  - Forward-select enum {FWD_RF, FWD_EXM, FWD_WB}.
- Sub-module prv32_fwd_unit: purely combinational; instantiated twice (rs1, rs2). Inputs: address, registered data, both writeback ports. Outputs: select and data.

Test Plan:
- Reset: rst_n=0 with id_valid=1, id_alufn=0001 -> next edge ex_valid=0, ex_alufn=0, ex_reg_write=0, stall_id=0.
- Plain advance: id_rs1_data=5, id_imm=7, id_bsel_imm=1, alufn=0000 -> one cycle later ex_a=5, ex_b=7, ex_valid=1.
- Forward priority: EX rs1=x3; exm_rd=3, exm_result=0x11; wb_rd=3, wb_data=0x22 -> ex_a=0x11. Drop exm_reg_write -> ex_a=0x22. With rs1=x0 and all rd=0 -> ex_a = registered rf data.
- Load-use: EX holds lw x5 (ex_mem_read=1); ID add x6,x5,x1 -> stall_id=1; next edge ex_valid=0. The following cycle the add enters, with x5 from wb_data.
- Flush vs hazard: set load_use and flush=1 together -> stall_id=0, next ex_valid=0, ex_reg_write=0.
- Hold: ex_hold=1 for 3 cycles while ID changes -> ex_pc and ex_a unchanged, stall_id=1; release -> the pending ID instruction loads.
